button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/car_pkg.sv | 24 ++
 rtl/button_debounce_if.sv | 34 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/button_debounce.sv | 165 ++++++++++++++++
 tb/tb_button_debounce.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/car_pkg.sv
// =============================================================================
// Module      : car_pkg
// Description : Shared state encodings and default timing constants for the
//               car input stages (button debounce and friends).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package car_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_ARM_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } btn_state_t;

    localparam int unsigned c_stable_count_def = 50000;
    localparam int unsigned c_long_count_def   = 50000000;
    localparam int unsigned c_cnt_w_def        = 26;

endpackage

`default_nettype wire

// File: rtl/button_debounce_if.sv
// =============================================================================
// Module      : button_debounce_if
// Description : Pin-side and event-side signals of the button debouncer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface button_debounce_if;

    logic button_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic long_press;

    modport master (
        output button_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  long_press
    );

    modport slave (
        input  button_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output long_press
    );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// =============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer with synchronous reset-to-0 stages.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic sysclk,
    input  wire logic reset,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// =============================================================================
// Module      : button_debounce
// Description : Pushbutton debouncer with press/release pulses and an optional
//               long-press pulse (enabled by macro BUTTON_LONG_PRESS_EN).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module button_debounce
    import car_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = c_stable_count_def,
    parameter int unsigned LONG_COUNT   = c_long_count_def,
    parameter int unsigned CNT_W        = c_cnt_w_def,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  wire logic        sysclk,
    input  wire logic        reset,
    button_debounce_if.slave btn
);

    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_COUNT - 1);

    generate
        if (STABLE_COUNT < 2 || longint'(STABLE_COUNT) > ((64'sd1 <<< CNT_W) - 1)) begin : g_bad_stable
            $error("button_debounce: STABLE_COUNT out of range for CNT_W");
        end
        if (LONG_COUNT <= STABLE_COUNT || longint'(LONG_COUNT) > ((64'sd1 <<< CNT_W) - 1)) begin : g_bad_long
            $error("button_debounce: LONG_COUNT must exceed STABLE_COUNT and fit CNT_W");
        end
    endgenerate

    logic w_raw;
    logic w_sync;

    assign w_raw = ACTIVE_LOW ? ~btn.button_raw : btn.button_raw;

    sync_2ff u_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .i_d    (w_raw),
        .o_q    (w_sync)
    );

    btn_state_t       r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_level,   w_level_nxt;
    logic             r_press,   w_press_nxt;
    logic             r_release, w_release_nxt;

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_COUNT - 1);

    logic r_long,      w_long_nxt;
    // Remembers that this press already fired, so a release glitch that
    // bounces back into PRESSED cannot produce a second long_press.
    logic r_long_done, w_long_done_nxt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        w_long_nxt      = 1'b0;
        w_long_done_nxt = r_long_done;
`endif
        case (r_state)
            ST_RELEASED: begin
                if (w_sync) begin
                    w_state_nxt = ST_ARM_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_PRESS: begin
                if (!w_sync) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = ST_PRESSED;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_cnt_nxt   = '0;
`ifdef BUTTON_LONG_PRESS_EN
                    w_long_done_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = ST_ARM_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef BUTTON_LONG_PRESS_EN
                    if (r_cnt == c_long_last) begin
                        if (!r_long_done) begin
                            w_long_nxt      = 1'b1;
                            w_long_done_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end
            end
            ST_ARM_RELEASE: begin
                if (w_sync) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt   = ST_RELEASED;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
`ifdef BUTTON_LONG_PRESS_EN
            r_long      <= w_long_nxt;
            r_long_done <= w_long_done_nxt;
`endif
        end
    end

    assign btn.btn_level   = r_level;
    assign btn.btn_press   = r_press;
    assign btn.btn_release = r_release;
`ifdef BUTTON_LONG_PRESS_EN
    assign btn.long_press  = r_long;
`else
    assign btn.long_press  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// =============================================================================
// Module      : tb_button_debounce
// Description : Directed self-checking bench for button_debounce
//               (STABLE_COUNT=4, LONG_COUNT=20, CNT_W=8, both polarities).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_button_debounce;

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic c_long_exp = 1'b1;
`else
    localparam logic c_long_exp = 1'b0;
`endif

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    button_debounce_if bif ();
    button_debounce_if bif_n ();

    button_debounce #(
        .STABLE_COUNT (4),
        .LONG_COUNT   (20),
        .CNT_W        (8),
        .ACTIVE_LOW   (1'b0)
    ) u_dut (
        .sysclk (sysclk),
        .reset  (reset),
        .btn    (bif)
    );

    button_debounce #(
        .STABLE_COUNT (4),
        .LONG_COUNT   (20),
        .CNT_W        (8),
        .ACTIVE_LOW   (1'b1)
    ) u_dut_n (
        .sysclk (sysclk),
        .reset  (reset),
        .btn    (bif_n)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic set_btn(input logic v);
        bif.button_raw   = v;
        bif_n.button_raw = ~v;
    endtask

    function automatic logic any_out();
        return bif.btn_level | bif.btn_press | bif.btn_release | bif.long_press;
    endfunction

    initial begin
        logic seen;
        set_btn(1'b0);
        reset = 1'b1;
        tick(3);
        check_eq("rst_level",     bif.btn_level,     1'b0);
        check_eq("rst_press",     bif.btn_press,     1'b0);
        check_eq("rst_release",   bif.btn_release,   1'b0);
        check_eq("rst_long",      bif.long_press,    1'b0);
        check_eq("rst_level_al",  bif_n.btn_level,   1'b0);
        reset = 1'b0;
        tick(2);
        check_eq("idle_quiet", any_out(), 1'b0);

        // Clean press: raised just after edge 0, accepted on edge 7.
        set_btn(1'b1);
        tick(6);
        check_eq("press_early_level", bif.btn_level, 1'b0);
        check_eq("press_early_pulse", bif.btn_press, 1'b0);
        tick(1);
        check_eq("press_level",    bif.btn_level,   1'b1);
        check_eq("press_pulse",    bif.btn_press,   1'b1);
        check_eq("press_level_al", bif_n.btn_level, 1'b1);
        check_eq("press_pulse_al", bif_n.btn_press, 1'b1);
        tick(1);
        check_eq("press_pulse_end", bif.btn_press, 1'b0);
        check_eq("press_hold",      bif.btn_level, 1'b1);

        // Long press: btn_press was on edge 7, long_press due on edge 27.
        tick(18);
        check_eq("long_early", bif.long_press, 1'b0);
        tick(1);
        check_eq("long_fire",  bif.long_press, c_long_exp);
        check_eq("long_no_press", bif.btn_press, 1'b0);
        seen = 1'b0;
        repeat (30) begin
            tick(1);
            seen |= bif.long_press;
        end
        check_eq("long_repeat", seen, 1'b0);

        // Release, symmetric timing.
        set_btn(1'b0);
        tick(6);
        check_eq("rel_early_level", bif.btn_level,   1'b1);
        check_eq("rel_early_pulse", bif.btn_release, 1'b0);
        tick(1);
        check_eq("rel_level",    bif.btn_level,   1'b0);
        check_eq("rel_pulse",    bif.btn_release, 1'b1);
        check_eq("rel_level_al", bif_n.btn_level, 1'b0);
        check_eq("rel_pulse_al", bif_n.btn_release, 1'b1);
        tick(1);
        check_eq("rel_pulse_end", bif.btn_release, 1'b0);
        tick(3);

        // Bounce: 2-high / 2-low for 20 cycles, then settle low.
        seen = 1'b0;
        repeat (5) begin
            set_btn(1'b1);
            repeat (2) begin tick(1); seen |= any_out() | bif_n.btn_level; end
            set_btn(1'b0);
            repeat (2) begin tick(1); seen |= any_out() | bif_n.btn_level; end
        end
        repeat (10) begin tick(1); seen |= any_out(); end
        check_eq("bounce_quiet", seen, 1'b0);

        // A high pulse exactly STABLE_COUNT cycles long is still rejected.
        seen = 1'b0;
        set_btn(1'b1);
        repeat (4) begin tick(1); seen |= any_out(); end
        set_btn(1'b0);
        repeat (10) begin tick(1); seen |= any_out(); end
        check_eq("glitch4_quiet", seen, 1'b0);

        // Reset while in ARM_PRESS with cnt=2, button kept held.
        set_btn(1'b1);
        tick(5);
        reset = 1'b1;
        tick(1);
        check_eq("midrst_level", bif.btn_level, 1'b0);
        check_eq("midrst_press", bif.btn_press, 1'b0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin tick(1); seen |= any_out(); end
        check_eq("midrst_quiet", seen, 1'b0);
        tick(1);
        check_eq("midrst_repress", bif.btn_press, 1'b1);
        check_eq("midrst_level2",  bif.btn_level, 1'b1);
        tick(1);
        check_eq("midrst_press_end", bif.btn_press, 1'b0);

        // Reset while PRESSED, button let go: no release pulse follows.
        reset = 1'b1;
        set_btn(1'b0);
        tick(1);
        check_eq("prsrst_level", bif.btn_level, 1'b0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin tick(1); seen |= any_out(); end
        check_eq("prsrst_quiet", seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
